sram_fifo_ctrl: RTL and testbench
=================================

Name: sram_fifo_ctrl

Overview:
Controller that turns one 1r1w SRAM macro (write port 0, read port 1, active-low chip selects, 1-cycle registered read) into a synchronous valid/ready FIFO. It sits between a producer stream and a consumer stream. It sequences SRAM write and read cycles, hides the read latency with a 2-entry output prefetch buffer, and tracks occupancy. Both SRAM clocks are tied to clk at the instantiating level.

Parameters:
DATA_WIDTH, 8, stream and SRAM word width
ADDR_WIDTH, 10, SRAM address width
DEPTH, 1024, usable FIFO capacity in words; must be ≤ 2**ADDR_WIDTH

Ports:
clk  in  1  clock; also drives SRAM clk0/clk1
rst  in  1  asynchronous active-high reset
flush  in  1  synchronous clear of all FIFO state
s_valid  in  1  producer word valid
s_ready  out  1  controller can accept a word
s_data  in  DATA_WIDTH  producer word
m_valid  out  1  output word valid
m_ready  in  1  consumer accepts the word
m_data  out  DATA_WIDTH  output word
count  out  ADDR_WIDTH+1  words held (SRAM + in flight + output buffer)
empty  out  1  count == 0
full  out  1  count == DEPTH
sram_csb0  out  1  SRAM write chip select, active low
sram_addr0  out  ADDR_WIDTH  SRAM write address
sram_din0  out  DATA_WIDTH  SRAM write data
sram_csb1  out  1  SRAM read chip select, active low
sram_addr1  out  ADDR_WIDTH  SRAM read address
sram_dout1  in  DATA_WIDTH  SRAM read data; valid at the posedge after the read is captured

Behaviour:
- Reset (async assert, sync release): wr_ptr=rd_ptr=0, count=0, empty=1, full=0, m_valid=0, m_data=0, sram_csb0=sram_csb1=1, addresses/din=0, in-flight flag cleared. s_ready=0 while rst is high.
- Push: the push handshake is s_valid && s_ready. s_ready = !full. s_ready has no combinational dependence on m_ready. On push, the controller drives sram_csb0=0, sram_addr0=wr_ptr and sram_din0=s_data for that cycle; wr_ptr increments and wraps DEPTH-1 -> 0.
- sram_pending = number of words written but not yet read-issued. A word pushed in cycle N counts toward sram_pending from cycle N+1, so read and write never target the same address in one cycle.
- Read issue: in cycle N, when sram_pending > 0 and (output buffer occupancy + in-flight reads) < 2 after this cycle's pop, the controller drives sram_csb1=0 and sram_addr1=rd_ptr, sets the in-flight flag, and increments/wraps rd_ptr. Otherwise sram_csb1=1.
- Read return: sram_dout1 is captured into the output buffer at the end of cycle N+1. At most one read is in flight.
- Output buffer: 2-entry FIFO. m_valid = buffer non-empty. m_data = head entry, stable while m_valid && !m_ready.
- Latency: push in cycle N into an empty FIFO -> m_valid=1 with that word in cycle N+2. Sustained throughput is 1 word/cycle in and out.
- count: +1 on push, -1 on pop (m_valid && m_ready). Push and pop in the same cycle leave count unchanged. Registered; empty and full are decoded from count.
- Full: count==DEPTH -> s_ready=0. A simultaneous pop frees a slot from the next cycle only.
- flush: highest priority after rst. All pointers, count, buffer and in-flight flag clear at the clock edge. Any read returning next cycle is discarded. A push presented in the flush cycle is dropped and no SRAM write is issued that cycle. The SRAM contents are not cleared.
- Ordering: words emerge in exact push order across pointer wrap.
- Idle SRAM port: its csb is held at 1 and its address/din hold the last value.

Test Plan:
- Reset, then push 0x11,0x22,0x33 back-to-back with m_ready=1 -> m_data 0x11 at push cycle+2, then 0x22, 0x33 on consecutive cycles; count peaks at 2 and returns to 0; empty=1 at end.
- Fill with m_ready=0: push 1024 words (value = index[7:0]) -> full=1 and s_ready=0 after the 1024th push; count=1024; a 1025th s_valid is not accepted; drain returns 0x00..0xFF repeating, in order.
- Simultaneous push/pop at full: one pop -> count 1023 next cycle; s_ready=1 next cycle only.
- Wrap: 3000 words streamed with random m_ready (50%) and s_valid (70%) -> scoreboard exact match; sram_addr0 and sram_addr1 never equal while both csb are 0 in the same cycle.
- Backpressure: m_ready=0 for 5 cycles with 4 words queued -> m_data holds the first word, at most 2 reads issued, sram_csb1=1 thereafter.
- flush with one read in flight and s_valid=1 -> next cycle count=0, m_valid=0, no sram_csb0 pulse in the flush cycle; the next push of 0xA5 appears at m_data 2 cycles later.
- Mid-stream async rst -> all outputs reach their reset values without a clock edge.

Source files
------------

// File: rtl/sram_fifo_ctrl.sv
// Valid/ready FIFO built on one 1r1w SRAM macro with a 2-entry output prefetch buffer.
// Latency: a push into an empty FIFO is presented on m_data two cycles later (read-return bypass).
// Backpressure: s_ready = !full; reads stop issuing once buffer + in-flight would exceed 2 entries.
module sram_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  sram_csb0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]         DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0]         ONE_C   = CW'(1);
  localparam logic [ADDR_WIDTH-1:0] LAST_A  = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE_A   = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]         sram_pending;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] buf_mem [0:1];
  logic                  buf_rd, buf_wr;
  logic [1:0]            buf_cnt;
  logic [ADDR_WIDTH-1:0] addr0_q, addr1_q;
  logic [DATA_WIDTH-1:0] din0_q;

  logic       push, pop, issue, cap, deq;
  logic [2:0] occ_after;

  function automatic logic [ADDR_WIDTH-1:0] next_ptr(input logic [ADDR_WIDTH-1:0] p);
    return (p == LAST_A) ? '0 : p + ONE_A;
  endfunction

  // Handshakes, read-issue decision and SRAM port drive.
  always_comb begin
    s_ready   = !rst && !full;
    push      = s_valid && s_ready && !flush;
    m_valid   = (buf_cnt != 2'd0) || inflight;
    // With the buffer empty, the returning read is presented straight from the macro.
    m_data    = (buf_cnt == 2'd0 && inflight) ? sram_dout1 : buf_mem[buf_rd];
    pop       = m_valid && m_ready;
    // Buffer occupancy at the end of this cycle, counting the read now returning.
    occ_after = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
    issue     = !rst && !flush && (sram_pending != '0) && (occ_after < 3'd2);
    // A returning word is buffered unless it is consumed directly via the bypass.
    cap       = inflight && !(buf_cnt == 2'd0 && pop);
    deq       = pop && (buf_cnt != 2'd0);
    sram_csb0  = !push;
    sram_addr0 = push ? wr_ptr : addr0_q;
    sram_din0  = push ? s_data : din0_q;
    sram_csb1  = !issue;
    sram_addr1 = issue ? rd_ptr : addr1_q;
    empty      = (count == '0);
    full       = (count == DEPTH_C);
  end

  // Pointers, occupancy, written-but-unread words and the in-flight flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      sram_pending <= '0;
      inflight     <= 1'b0;
    end else if (flush) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      sram_pending <= '0;
      inflight     <= 1'b0;
    end else begin
      if (push)  wr_ptr <= next_ptr(wr_ptr);
      if (issue) rd_ptr <= next_ptr(rd_ptr);
      inflight <= issue;
      case ({push, pop})
        2'b10:   count <= count + ONE_C;
        2'b01:   count <= count - ONE_C;
        default: count <= count;
      endcase
      case ({push, issue})
        2'b10:   sram_pending <= sram_pending + ONE_C;
        2'b01:   sram_pending <= sram_pending - ONE_C;
        default: sram_pending <= sram_pending;
      endcase
    end
  end

  // Two-entry output buffer fed by read returns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_mem[0] <= '0;
      buf_mem[1] <= '0;
      buf_rd     <= 1'b0;
      buf_wr     <= 1'b0;
      buf_cnt    <= 2'd0;
    end else if (flush) begin
      buf_rd  <= 1'b0;
      buf_wr  <= 1'b0;
      buf_cnt <= 2'd0;
    end else begin
      if (cap) begin
        buf_mem[buf_wr] <= sram_dout1;
        buf_wr          <= !buf_wr;
      end
      if (deq) buf_rd <= !buf_rd;
      case ({cap, deq})
        2'b10:   buf_cnt <= buf_cnt + 2'd1;
        2'b01:   buf_cnt <= buf_cnt - 2'd1;
        default: buf_cnt <= buf_cnt;
      endcase
    end
  end

  // Idle SRAM ports keep presenting the last address/data they used.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr0_q <= '0;
      din0_q  <= '0;
      addr1_q <= '0;
    end else begin
      if (push) begin
        addr0_q <= wr_ptr;
        din0_q  <= s_data;
      end
      if (issue) addr1_q <= rd_ptr;
    end
  end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Bench for sram_fifo_ctrl with a behavioural 1r1w SRAM and a push-order scoreboard.
// Directed vectors plus a randomised streaming phase; checks sampled on the falling edge.
// Stimulus is driven 1 time unit after each rising edge.
module tb_sram_fifo_ctrl;
  localparam int DW = 8;
  localparam int AW = 10;
  localparam int DEPTH = 1024;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic [AW:0]   count;
  logic          empty, full;
  logic          sram_csb0, sram_csb1;
  logic [AW-1:0] sram_addr0, sram_addr1;
  logic [DW-1:0] sram_din0;
  logic [DW-1:0] sram_dout1 = '0;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] sb_q [$];
  int checks = 0;
  int errors = 0;
  int rd_issue_total = 0;

  sram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .count(count), .empty(empty), .full(full),
    .sram_csb0(sram_csb0), .sram_addr0(sram_addr0), .sram_din0(sram_din0),
    .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1)
  );

  always #5 clk = ~clk;

  // 1r1w macro model: write on port 0, registered read on port 1.
  always @(posedge clk) begin
    if (!sram_csb0) mem[sram_addr0] <= sram_din0;
    if (!sram_csb1) sram_dout1 <= mem[sram_addr1];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: records accepted pushes, compares every pop, watches port collisions.
  always @(negedge clk) begin
    if (rst || flush) begin
      sb_q.delete();
    end else begin
      if (!sram_csb1) rd_issue_total++;
      if (!sram_csb0 && !sram_csb1) chk("addr_collision", {31'd0, sram_addr0 == sram_addr1}, 32'd0);
      if (m_valid && m_ready) begin
        if (sb_q.size() == 0) chk("pop_unexpected", 32'd1, 32'd0);
        else chk("sb_data", {24'd0, m_data}, {24'd0, sb_q.pop_front()});
      end
      if (s_valid && s_ready) sb_q.push_back(s_data);
    end
  end

  task automatic drain(input string name);
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 1500 && !empty; i++) step();
    step();
    chk(name, {31'd0, empty}, 32'd1);
    chk("sb_drained", sb_q.size(), 32'd0);
    m_ready = 1'b0;
  endtask

  initial begin
    int pushed;
    int rd_base;
    // Reset values
    #1;
    chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
    chk("rst_count", {21'd0, count}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_m_data", {24'd0, m_data}, 32'd0);
    chk("rst_csb", {30'd0, sram_csb0, sram_csb1}, 32'd3);
    chk("rst_addr_din", {6'd0, sram_addr0, sram_addr1, sram_din0}, 32'd0);
    step(); step();
    rst = 1'b0;
    step();

    // Three back-to-back pushes with the consumer ready
    m_ready = 1'b1;
    s_valid = 1'b1; s_data = 8'h11; step();
    chk("t1_count_a", {21'd0, count}, 32'd1);
    s_data = 8'h22; step();
    chk("t1_count_b", {21'd0, count}, 32'd2);
    chk("t1_lat_valid", {31'd0, m_valid}, 32'd1);
    chk("t1_lat_data", {24'd0, m_data}, 32'h11);
    s_data = 8'h33; step();
    chk("t1_count_c", {21'd0, count}, 32'd2);
    chk("t1_data2", {24'd0, m_data}, 32'h22);
    s_valid = 1'b0; step();
    chk("t1_count_d", {21'd0, count}, 32'd1);
    chk("t1_data3", {24'd0, m_data}, 32'h33);
    step();
    chk("t1_count_e", {21'd0, count}, 32'd0);
    chk("t1_empty", {31'd0, empty}, 32'd1);
    chk("t1_m_valid", {31'd0, m_valid}, 32'd0);

    // Fill to capacity with the consumer stalled
    m_ready = 1'b0;
    s_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      s_data = i[7:0];
      step();
    end
    s_data = 8'hEE;
    #1;
    chk("t2_count_full", {21'd0, count}, 32'd1024);
    chk("t2_full", {31'd0, full}, 32'd1);
    chk("t2_s_ready", {31'd0, s_ready}, 32'd0);
    step();
    chk("t2_no_1025th", {21'd0, count}, 32'd1024);
    chk("t2_head", {24'd0, m_data}, 32'h00);

    // Pop while full with s_valid held: slot frees next cycle only
    m_ready = 1'b1;
    #1;
    chk("t3_s_ready_same", {31'd0, s_ready}, 32'd0);
    step();
    s_valid = 1'b0;
    m_ready = 1'b0;
    #1;
    chk("t3_count", {21'd0, count}, 32'd1023);
    chk("t3_s_ready_next", {31'd0, s_ready}, 32'd1);
    drain("t2_drain_empty");

    // Random streaming across several pointer wraps
    pushed = 0;
    for (int cyc = 0; cyc < 20000 && pushed < 3000; cyc++) begin
      s_valid = ($urandom_range(0, 99) < 70);
      s_data  = pushed[7:0] ^ 8'h5A;
      m_ready = ($urandom_range(0, 1) == 1);
      #1;
      if (s_valid && s_ready) pushed++;
      step();
    end
    chk("t4_pushed", pushed, 32'd3000);
    drain("t4_drain_empty");

    // Consumer stalled with four words queued
    rd_base = rd_issue_total;
    s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_data = 8'hA0 + 8'(i);
      step();
    end
    s_valid = 1'b0;
    repeat (5) step();
    chk("t5_reads", rd_issue_total - rd_base, 32'd2);
    chk("t5_head", {24'd0, m_data}, 32'hA0);
    chk("t5_m_valid", {31'd0, m_valid}, 32'd1);
    chk("t5_csb1_idle", {31'd0, sram_csb1}, 32'd1);
    chk("t5_count", {21'd0, count}, 32'd4);
    drain("t5_drain_empty");

    // Flush with a read in flight and a push offered
    s_valid = 1'b1; s_data = 8'h5C; step();
    s_valid = 1'b0; step();
    flush = 1'b1; s_valid = 1'b1; s_data = 8'h77;
    #1;
    chk("t6_no_write", {31'd0, sram_csb0}, 32'd1);
    step();
    flush = 1'b0; s_valid = 1'b0;
    #1;
    chk("t6_count", {21'd0, count}, 32'd0);
    chk("t6_m_valid", {31'd0, m_valid}, 32'd0);
    s_valid = 1'b1; s_data = 8'hA5; step();
    s_valid = 1'b0; step();
    chk("t6_a5_valid", {31'd0, m_valid}, 32'd1);
    chk("t6_a5_data", {24'd0, m_data}, 32'hA5);
    chk("t6_a5_count", {21'd0, count}, 32'd1);
    drain("t6_drain_empty");

    // Asynchronous reset mid-stream, checked before any clock edge
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_data = 8'hB1 + 8'(i);
      step();
    end
    s_data = 8'hB4;
    #2;
    rst = 1'b1;
    #1;
    chk("t7_count", {21'd0, count}, 32'd0);
    chk("t7_empty", {31'd0, empty}, 32'd1);
    chk("t7_full", {31'd0, full}, 32'd0);
    chk("t7_m_valid", {31'd0, m_valid}, 32'd0);
    chk("t7_m_data", {24'd0, m_data}, 32'd0);
    chk("t7_s_ready", {31'd0, s_ready}, 32'd0);
    chk("t7_csb", {30'd0, sram_csb0, sram_csb1}, 32'd3);
    chk("t7_addr_din", {6'd0, sram_addr0, sram_addr1, sram_din0}, 32'd0);
    s_valid = 1'b0;
    step();
    rst = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
